banco_registradores: RTL and testbench

//  Integer register file plus registered operand stage feeding the ULA's dina/dinb/constante inputs.

---
 rtl/banco_pkg.sv | 11 +
 rtl/memoria_registradores.sv | 36 +++
 rtl/banco_registradores.sv | 83 ++++++++
 tb/tb_banco_registradores.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// banco_pkg: shared constants, index type and width helper for the register file
package banco_pkg;
  localparam int BITS_DEF = 64;
  localparam int NREGS_DEF = 32;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ADDR_W_DEF = addr_w(NREGS_DEF);
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/memoria_registradores.sv
// memoria_registradores: register storage, 2 async read ports, 1 sync write port, x0 hardwired to zero
module memoria_registradores
  import banco_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [BITS-1:0]   rdata1,
  output logic [BITS-1:0]   rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [BITS-1:0]   wdata
);
  logic [BITS-1:0] regs_q [NREGS];
  logic [BITS-1:0] regs_d [NREGS];
  // next storage contents: a write to x0 is dropped here
  always_comb begin
    regs_d = regs_q;
    if (we && wa != ADDR_W'(REG_ZERO)) regs_d[wa] = wdata;
  end
  // storage update, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end
  // read ports: x0 always returns zero regardless of storage
  always_comb begin
    rdata1 = (ra1 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[ra1];
    rdata2 = (ra2 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[ra2];
  end
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: register file with registered operand stage for the ULA
// Optional macro WRITE_BYPASS_EN: a same-cycle write to a captured source is forwarded (write-first);
// without it capture sees the pre-write contents (read-first).
module banco_registradores
  import banco_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [BITS-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   dina,
  output logic [BITS-1:0]   dinb,
  output logic [BITS-1:0]   constante,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [BITS-1:0]   wdata
);
  logic            valid_q, valid_d, fire;
  logic [BITS-1:0] a_q, a_d, b_q, b_d, k_q, k_d;
  logic [BITS-1:0] rdata1, rdata2, op_a, op_b;

  memoria_registradores #(.BITS(BITS), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .we    (we),
    .wa    (rd),
    .wdata (wdata)
  );

  // operand selection: forward writeback data on a same-index hazard when enabled
  always_comb begin
`ifdef WRITE_BYPASS_EN
    op_a = (we && rd != ADDR_W'(REG_ZERO) && rd == rs1) ? wdata : rdata1;
    op_b = (we && rd != ADDR_W'(REG_ZERO) && rd == rs2) ? wdata : rdata2;
`else
    op_a = rdata1;
    op_b = rdata2;
`endif
  end

  // handshake and next state: capture on fire, drop valid when consumed, otherwise hold
  always_comb begin
    in_ready = !valid_q || out_ready;
    fire     = in_valid && in_ready;
    valid_d  = fire ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    a_d      = fire ? op_a : a_q;
    b_d      = fire ? op_b : b_q;
    k_d      = fire ? imm : k_q;
  end

  // output stage registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
    end
  end

  assign out_valid = valid_q;
  assign dina      = a_q;
  assign dinb      = b_q;
  assign constante = k_q;
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed self-checking bench for banco_registradores
module tb_banco_registradores;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, we = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic [63:0] imm = 0, dina, dinb, constante, wdata = 0;
  int passed = 0, total = 0;

  banco_registradores dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .dina(dina), .dinb(dinb), .constante(constante), .we(we), .rd(rd), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    we = 1; rd = r; wdata = d;
    step();
    we = 0;
  endtask

  task automatic capture(input logic [4:0] a, input logic [4:0] b, input logic [63:0] k);
    in_valid = 1; rs1 = a; rs2 = b; imm = k;
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
    total++; if ({dina, dinb, constante} !== '0) $display("FAIL reset_data got %h %h %h want 0", dina, dinb, constante); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    rst_n = 1;
    step();
  endtask

  task automatic test_write_read();
    out_ready = 1;
    wr(5, 64'h1234);
    in_valid = 1; rs1 = 5; rs2 = 0; imm = 64'hFFFF_FFFF_FFFF_FFFC;
    total++; if (out_valid !== 1'b0) $display("FAIL wr_pre_valid got %0b want 0", out_valid); else passed++;
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL wr_valid got %0b want 1", out_valid); else passed++;
    total++; if (dina !== 64'h1234) $display("FAIL wr_dina got %h want 1234", dina); else passed++;
    total++; if (dinb !== 64'h0) $display("FAIL wr_dinb got %h want 0", dinb); else passed++;
    total++; if (constante !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wr_const got %h want fffffffffffffffc", constante); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL wr_drain_valid got %0b want 0", out_valid); else passed++;
    total++; if (dina !== 64'h1234) $display("FAIL wr_hold_dina got %h want 1234", dina); else passed++;
  endtask

  task automatic test_x0();
    wr(0, 64'hDEAD);
    capture(0, 0, 64'h7);
    total++; if (dina !== 64'h0) $display("FAIL x0_dina got %h want 0", dina); else passed++;
    total++; if (dinb !== 64'h0) $display("FAIL x0_dinb got %h want 0", dinb); else passed++;
    step();
  endtask

  task automatic test_backpressure();
    wr(7, 64'd9);
    out_ready = 0;
    capture(7, 7, 64'h0);
    total++; if (dina !== 64'd9) $display("FAIL bp_capture got %0d want 9", dina); else passed++;
    in_valid = 1; rs1 = 7; rs2 = 7;
    for (int i = 0; i < 3; i++) begin
      we = (i == 0); rd = 7; wdata = 64'd11;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); else passed++;
      step();
      we = 0;
      total++; if (dina !== 64'd9 || out_valid !== 1'b1) $display("FAIL bp_hold[%0d] got dina=%0d valid=%0b want 9/1", i, dina, out_valid); else passed++;
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release got %0b want 1", in_ready); else passed++;
    step();
    in_valid = 0;
    total++; if (dina !== 64'd11 || dinb !== 64'd11) $display("FAIL bp_recapture got %0d/%0d want 11/11", dina, dinb); else passed++;
    step();
  endtask

  task automatic test_hazard();
    logic [63:0] exp_a;
`ifdef WRITE_BYPASS_EN
    exp_a = 64'd2;
`else
    exp_a = 64'd1;
`endif
    wr(3, 64'd1);
    we = 1; rd = 3; wdata = 64'd2;
    in_valid = 1; rs1 = 3; rs2 = 0; imm = 0;
    step();
    we = 0; in_valid = 0;
    total++; if (dina !== exp_a) $display("FAIL hazard_dina got %0d want %0d", dina, exp_a); else passed++;
    capture(3, 3, 0);
    total++; if (dina !== 64'd2 || dinb !== 64'd2) $display("FAIL hazard_stored got %0d/%0d want 2/2", dina, dinb); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) wr(5'(i), 64'(100 + i));
    out_ready = 1; in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      rs1 = 5'(i); rs2 = 5'(9 - i); imm = 64'(i);
      step();
      total++;
      if (out_valid !== 1'b1 || dina !== 64'(100 + i) || dinb !== 64'(109 - i) || constante !== 64'(i))
        $display("FAIL b2b[%0d] got v=%0b a=%0d b=%0d k=%0d want 1/%0d/%0d/%0d", i, out_valid, dina, dinb, constante, 100 + i, 109 - i, i);
      else passed++;
    end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_midrun();
    out_ready = 0;
    capture(8, 1, 64'h55);
    total++; if (out_valid !== 1'b1 || dina !== 64'd108) $display("FAIL mid_pre got v=%0b a=%0d want 1/108", out_valid, dina); else passed++;
    #2;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_valid got %0b want 0", out_valid); else passed++;
    total++; if ({dina, dinb, constante} !== '0) $display("FAIL mid_data got %h %h %h want 0", dina, dinb, constante); else passed++;
    step();
    rst_n = 1;
    out_ready = 1; in_valid = 1; imm = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      step();
      total++;
      if (dina !== 64'h0 || dinb !== 64'h0) $display("FAIL mid_clear[%0d] got %h/%h want 0/0", i, dina, dinb);
      else passed++;
    end
    in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_backpressure();
    test_hazard();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
